// File: rtl/bcd_encoder.sv
// Registered 8-bit binary to 3-digit packed BCD converter for the stopwatch display path.
// Conversion is a fully unrolled shift-and-add-3 network feeding one output register.
module bcd_encoder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  BinaryIn,
  output logic [11:0] BCDOut
);

  logic [19:0] scratch;

  // Double-dabble: each digit field is nudged by 3 before the shift so that
  // a value of 5 or more carries correctly into the next decimal digit.
  always_comb begin
    scratch = {12'd0, BinaryIn};
    for (int step = 0; step < 8; step++) begin
      if (scratch[11:8] >= 4'd5) begin
        scratch[11:8] = scratch[11:8] + 4'd3;
      end
      if (scratch[15:12] >= 4'd5) begin
        scratch[15:12] = scratch[15:12] + 4'd3;
      end
      if (scratch[19:16] >= 4'd5) begin
        scratch[19:16] = scratch[19:16] + 4'd3;
      end
      scratch = scratch << 1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BCDOut <= 12'h000;
    end else begin
      BCDOut <= scratch[19:8];
    end
  end

endmodule

// File: tb/tb_bcd_encoder.sv
// Self-checking bench for bcd_encoder: vector table, exhaustive sweep and reset corners,
// with expected values queued at drive time and popped one edge later.
module tb_bcd_encoder;

  logic        Clk;
  logic        Reset;
  logic [7:0]  BinaryIn;
  logic [11:0] BCDOut;

  int checks;
  int passes;
  logic [11:0] expQ[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vector_t;

  vector_t vectors[12];

  bcd_encoder dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BinaryIn (BinaryIn),
    .BCDOut   (BCDOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference digits come from integer division, independent of the shift network.
  function automatic logic [11:0] model(input int value);
    logic [3:0] h, t, o;
    h = 4'(value / 100);
    t = 4'((value / 10) % 10);
    o = 4'(value % 10);
    return {h, t, o};
  endfunction

  task automatic compare(input string name, input logic [11:0] actual, input logic [11:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic [11:0] expected);
    @(negedge Clk);
    BinaryIn = value;
    expQ.push_back(expected);
  endtask

  task automatic checkOutput(input string name);
    logic [11:0] expected;
    @(posedge Clk);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s: scoreboard empty, got %h, expected a queued value", name, BCDOut);
    end else begin
      expected = expQ.pop_front();
      compare(name, BCDOut, expected);
    end
  endtask

  task automatic checkLegal(input string name);
    checks++;
    if (BCDOut[11:8] <= 4'd2 && BCDOut[7:4] <= 4'd9 && BCDOut[3:0] <= 4'd9) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, required digits h<=2 t<=9 o<=9", name, BCDOut);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;

    vectors[0]  = '{8'd0,   12'h000};
    vectors[1]  = '{8'd9,   12'h009};
    vectors[2]  = '{8'd10,  12'h010};
    vectors[3]  = '{8'd99,  12'h099};
    vectors[4]  = '{8'd100, 12'h100};
    vectors[5]  = '{8'd199, 12'h199};
    vectors[6]  = '{8'd200, 12'h200};
    vectors[7]  = '{8'd255, 12'h255};
    vectors[8]  = '{8'd123, 12'h123};
    vectors[9]  = '{8'd58,  12'h058};
    vectors[10] = '{8'd190, 12'h190};
    vectors[11] = '{8'd1,   12'h001};

    // Reset holds the output at zero with and without clock edges.
    Reset = 1'b1;
    BinaryIn = 8'd123;
    #1;
    compare("reset_async", BCDOut, 12'h000);
    repeat (2) @(posedge Clk);
    #1;
    compare("reset_held", BCDOut, 12'h000);

    @(negedge Clk);
    Reset = 1'b0;
    expQ.push_back(12'h123);
    checkOutput("reset_release");

    // Table vectors on consecutive cycles cover every carry boundary.
    foreach (vectors[k]) begin
      applyStimulus(vectors[k].bin, vectors[k].bcd);
      checkOutput($sformatf("vector_%0d", vectors[k].bin));
    end

    // Exhaustive sweep with an asynchronous reset pulse between edges at 128.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), model(i));
      checkOutput($sformatf("sweep_%0d", i));
      checkLegal($sformatf("legal_%0d", i));
      if (i == 128) begin
        #1;
        Reset = 1'b1;
        #1;
        compare("midstream_reset", BCDOut, 12'h000);
        Reset = 1'b0;
        expQ.push_back(model(i));
        checkOutput("midstream_release");
      end
    end

    // Alternating extremes must never show an intermediate value.
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) begin
        applyStimulus(8'd0, 12'h000);
      end else begin
        applyStimulus(8'd255, 12'h255);
      end
      checkOutput($sformatf("alternate_%0d", j));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
